bch_key_sched: RTL and testbench
================================

BCH_KEY_SCHED -- requirements
Module: bch_key_sched

Interface
REQ-001 SHALL have parameter NCHANNEL, default 4: number of syndrome channels requesting key-equation service.
REQ-002 SHALL have parameter NKEY, default 2: number of shared key-equation solvers.
REQ-003 SHALL have parameter SYN_WIDTH, default 24: width of one channel's packed syndrome word.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- syn_ready  in  NCHANNEL  per-channel request level; held until acknowledged.
- syn_data  in  NCHANNEL*SYN_WIDTH  per-channel syndrome word.
- syn_ack  out  NCHANNEL  one-cycle pulse when the channel's syndrome is captured.
- key_start  out  NKEY  one-cycle pulse that launches a solver.
- key_syn  out  NKEY*SYN_WIDTH  registered syndrome for each solver.
- key_chan  out  NKEY*CHAN_BITS  source channel tag; CHAN_BITS = max(1, clog2(NCHANNEL)).
- key_busy  in  NKEY  solver busy level.

Function
REQ-005 SHALL run one FSM per solver slot, with states IDLE, ARMED and RUN.
REQ-006 Slot transitions:
- IDLE->ARMED on grant.
- ARMED->RUN when key_busy is seen high.
- RUN->IDLE when key_busy is seen low.
REQ-007 SHALL make at most one grant per cycle.
REQ-008 A grant requires at least one eligible channel and at least one IDLE slot.
REQ-009 A channel is eligible when syn_ready=1 and its syn_ack is not currently high.
REQ-010 SHALL choose the channel round-robin, starting at the index after the last granted channel and wrapping NCHANNEL-1->0; the pointer resets to 0.
REQ-011 SHALL choose the lowest-index IDLE slot.
REQ-012 When a grant is decided at edge N, syn_ack[c], key_start[k], key_syn[k]=syn_data[c] and key_chan[k]=c SHALL all be valid in cycle N+1.
REQ-013 key_syn and key_chan SHALL hold their values until the next grant to the same slot.
REQ-014 A requester may keep syn_ready high during its ack cycle without being granted twice.
REQ-015 A slot in ARMED SHALL NOT be regranted.
REQ-016 A slot SHALL stay ARMED indefinitely if key_busy never rises (no timeout).
REQ-017 key_busy high while a slot is IDLE SHALL be ignored.
REQ-018 If all slots are busy, requests SHALL wait with no loss and no ack.
REQ-019 A slot that returns to IDLE at edge N SHALL be grantable at edge N+1.
REQ-020 If NKEY >= NCHANNEL, all simultaneous requests SHALL be served within NCHANNEL cycles.

Reset
REQ-021 While reset_n=0, the block SHALL force:
- all slots IDLE;
- syn_ack=0, key_start=0, key_syn=0, key_chan=0;
- round-robin pointer=0.
REQ-022 Reset mid-operation SHALL abandon in-flight grants.
REQ-023 After reset the block SHALL require requesters to re-present syn_ready.

Configuration
REQ-024 With macro BCH_SCHED_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits).
REQ-025 stall_cnt SHALL increment in each cycle where some channel is eligible and no slot is IDLE.
REQ-026 stall_cnt SHALL saturate at 16'hFFFF and clear on reset.
REQ-027 Without BCH_SCHED_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-028 Slot-state encoding and the CHAN_BITS helper function SHALL live in shared package bch_sched_pkg.
REQ-029 The round-robin channel picker SHALL be sub-module bch_rr_pick.
REQ-030 bch_rr_pick SHALL take a request vector and a pointer, and return the grant index and a valid flag.

Verification
REQ-031 Single request: syn_ready=4'b0100 at edge 0, all slots IDLE -> cycle 1 shows syn_ack=4'b0100, key_start=2'b01, key_chan[0]=2, key_syn[0]=syn_data[2].
REQ-032 Fairness: syn_ready=4'b1111 held, solvers always free -> grants in channel order 0,1,2,3 over consecutive cycles, then wrap to 0.
REQ-033 Saturation: both slots RUN, channel 1 requesting for 20 cycles -> no syn_ack, no key_start.
REQ-034 Saturation release: from REQ-033, drop key_busy[1] -> slot 1 grants channel 1 two edges later.
REQ-035 With BCH_SCHED_STALL_CNT_EN defined, the REQ-033 run SHALL end with stall_cnt=20.
REQ-036 Stuck solver: key_busy[0] never rises after a launch -> slot 0 stays ARMED and all grants go to slot 1.
REQ-037 Reset mid-run: reset_n=0 for 1 cycle while slot 0 is ARMED -> all outputs 0 and the next request is granted to slot 0 from pointer 0.

Source files
------------

// File: rtl/bch_sched_pkg.sv
// Shared types and helpers for the BCH key-equation scheduler.
// Holds the solver-slot state encoding and the channel-tag width helper.
package bch_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } slot_state_t;

    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bch_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Returns the winning index and whether any request was set.
module bch_rr_pick
    import bch_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int CB = chan_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CB-1:0] ptr,
    output logic [CB-1:0] idx,
    output logic          valid
);

    // scan from the far end so the entry nearest ptr is written last
    always_comb begin
        int k;
        k     = 0;
        idx   = '0;
        valid = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            k = (int'(ptr) + j) % N;
            if (req[k]) begin
                idx   = CB'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bch_key_sched.sv
// Hands channel syndromes to a pool of shared key-equation solvers.
// Optional stall counter output enabled by macro BCH_SCHED_STALL_CNT_EN.
module bch_key_sched
    import bch_sched_pkg::*;
#(
    parameter int NCHANNEL  = 4,
    parameter int NKEY      = 2,
    parameter int SYN_WIDTH = 24
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NCHANNEL-1:0]                 syn_ready,
    input  logic [NCHANNEL*SYN_WIDTH-1:0]       syn_data,
    output logic [NCHANNEL-1:0]                 syn_ack,
    output logic [NKEY-1:0]                     key_start,
    output logic [NKEY*SYN_WIDTH-1:0]           key_syn,
    output logic [NKEY*chan_bits(NCHANNEL)-1:0] key_chan,
    input  logic [NKEY-1:0]                     key_busy
`ifdef BCH_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                         stall_cnt
`endif
);

    localparam int CB = chan_bits(NCHANNEL);

    slot_state_t state_q [NKEY];
    slot_state_t state_d [NKEY];

    logic [CB-1:0]        rr_ptr;
    logic [CB-1:0]        pick_idx;
    logic                 pick_valid;
    logic [NCHANNEL-1:0]  elig;
    logic [NKEY-1:0]      idle_vec;
    logic [NKEY-1:0]      slot_oh;
    logic                 grant;
    logic [NCHANNEL-1:0]  ack_oh;
    logic [SYN_WIDTH-1:0] sel_data;

    // a channel already being acked this cycle must not win again
    assign elig = syn_ready & ~syn_ack;

    bch_rr_pick #(
        .N  (NCHANNEL),
        .CB (CB)
    ) u_pick (
        .req   (elig),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // idle slot map and lowest-index idle slot as a one-hot
    always_comb begin
        idle_vec = '0;
        for (int k = 0; k < NKEY; k++) begin
            idle_vec[k] = (state_q[k] == S_IDLE);
        end
        slot_oh = idle_vec & (~idle_vec + NKEY'(1));
    end

    assign grant    = pick_valid & (|idle_vec);
    assign sel_data = syn_data[int'(pick_idx)*SYN_WIDTH +: SYN_WIDTH];

    // one-hot ack for the picked channel
    always_comb begin
        ack_oh           = '0;
        ack_oh[pick_idx] = 1'b1;
    end

    // per-slot next state: grant arms, busy high runs, busy low frees
    always_comb begin
        state_d = state_q;
        for (int k = 0; k < NKEY; k++) begin
            unique case (state_q[k])
                S_IDLE: begin
                    if (grant && slot_oh[k]) state_d[k] = S_ARMED;
                end
                S_ARMED: begin
                    if (key_busy[k]) state_d[k] = S_RUN;
                end
                S_RUN: begin
                    if (!key_busy[k]) state_d[k] = S_IDLE;
                end
                default: state_d[k] = S_IDLE;
            endcase
        end
    end

    // slot states, grant pulses, captured syndromes and rr pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NKEY; k++) begin
                state_q[k] <= S_IDLE;
            end
            syn_ack   <= '0;
            key_start <= '0;
            key_syn   <= '0;
            key_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                state_q[k] <= state_d[k];
            end
            syn_ack   <= grant ? ack_oh : '0;
            key_start <= grant ? slot_oh : '0;
            if (grant) begin
                for (int k = 0; k < NKEY; k++) begin
                    if (slot_oh[k]) begin
                        key_syn[k*SYN_WIDTH +: SYN_WIDTH] <= sel_data;
                        key_chan[k*CB +: CB]              <= pick_idx;
                    end
                end
                rr_ptr <= (int'(pick_idx) == NCHANNEL - 1) ? '0
                                                           : pick_idx + CB'(1);
            end
        end
    end

`ifdef BCH_SCHED_STALL_CNT_EN
    // count cycles where work is waiting but every solver is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((|elig) && !(|idle_vec) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bch_key_sched.sv
// Self-checking bench for bch_key_sched: directed scenarios plus
// randomized traffic against a behavioural scheduler model.
module tb_bch_key_sched;

    localparam int NCH = 4;
    localparam int NK  = 2;
    localparam int SW  = 24;
    localparam int CB  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    syn_ready;
    logic [NCH*SW-1:0] syn_data;
    logic [NCH-1:0]    syn_ack;
    logic [NK-1:0]     key_start;
    logic [NK*SW-1:0]  key_syn;
    logic [NK*CB-1:0]  key_chan;
    logic [NK-1:0]     key_busy;
`ifdef BCH_SCHED_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bch_key_sched #(
        .NCHANNEL  (NCH),
        .NKEY      (NK),
        .SYN_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .syn_ready (syn_ready),
        .syn_data  (syn_data),
        .syn_ack   (syn_ack),
        .key_start (key_start),
        .key_syn   (key_syn),
        .key_chan  (key_chan),
        .key_busy  (key_busy)
`ifdef BCH_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // behavioural model: slot status 0=free 1=launched 2=solving
    int              ms [NK];
    int              mptr;
    int              m_stall;
    logic [NCH-1:0]  m_ack;
    logic [NK-1:0]   m_start;
    logic [NK*SW-1:0] m_syn;
    logic [NK*CB-1:0] m_chan;

    task automatic model_reset();
        for (int k = 0; k < NK; k++) ms[k] = 0;
        mptr    = 0;
        m_stall = 0;
        m_ack   = '0;
        m_start = '0;
        m_syn   = '0;
        m_chan  = '0;
    endtask

    task automatic model_step();
        logic [NCH-1:0] el;
        int c;
        int s;
        el = syn_ready & ~m_ack;
        c  = -1;
        s  = -1;
        for (int j = 0; j < NCH; j++) begin
            if (c < 0 && el[(mptr + j) % NCH]) c = (mptr + j) % NCH;
        end
        for (int k = 0; k < NK; k++) begin
            if (s < 0 && ms[k] == 0) s = k;
        end
        if (el != 0 && s < 0 && m_stall < 65535) m_stall++;
        for (int k = 0; k < NK; k++) begin
            if (ms[k] == 1 && key_busy[k]) ms[k] = 2;
            else if (ms[k] == 2 && !key_busy[k]) ms[k] = 0;
        end
        m_ack   = '0;
        m_start = '0;
        if (c >= 0 && s >= 0) begin
            m_ack[c]            = 1'b1;
            m_start[s]          = 1'b1;
            m_syn[s*SW +: SW]   = syn_data[c*SW +: SW];
            m_chan[s*CB +: CB]  = CB'(c);
            mptr                = (c + 1) % NCH;
            ms[s]               = 1;
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        syn_ready = '0;
        key_busy  = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int fexp [5] = '{0, 1, 2, 3, 0};
        int n;
        int got;
        logic [NCH-1:0] e;
        logic [CB-1:0] gch;

        reset_n   = 1'b0;
        syn_ready = '0;
        syn_data  = '0;
        key_busy  = '0;
        @(negedge clk);
        check("reset_out", {syn_ack, key_start, key_syn, key_chan}, 64'd0);
        reset_n = 1'b1;

        // single request on channel 2
        for (int i = 0; i < NCH; i++) syn_data[i*SW +: SW] = SW'($urandom);
        syn_ready = 4'b0100;
        @(negedge clk);
        check("single_ack", syn_ack, 4'b0100);
        check("single_start", key_start, 2'b01);
        check("single_chan", key_chan[1:0], 2'd2);
        check("single_syn", key_syn[SW-1:0], syn_data[2*SW +: SW]);
        syn_ready = '0;
        key_busy  = 2'b01;
        @(negedge clk);
        check("single_ack_off", {syn_ack, key_start}, 6'd0);
        check("single_hold", key_syn[SW-1:0], syn_data[2*SW +: SW]);
        key_busy = '0;
        @(negedge clk);

        // fairness with all channels requesting
        do_reset();
        syn_ready = 4'hF;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (key_start != 0) begin
                gch = key_start[0] ? key_chan[1:0] : key_chan[3:2];
                check("fair_chan", gch, fexp[n]);
                e = '0;
                e[fexp[n]] = 1'b1;
                check("fair_ack", syn_ack, e);
                n++;
            end
            key_busy = key_start;
        end
        check("fair_count", n, 5);

        // saturation: both slots solving, channel 1 waits
        do_reset();
        key_busy  = 2'b11;
        syn_ready = 4'b0101;
        @(negedge clk);
        check("sat_setup0", syn_ack, 4'b0001);
        syn_ready = 4'b0100;
        @(negedge clk);
        check("sat_setup1", syn_ack, 4'b0100);
        syn_ready = '0;
        @(negedge clk);
        syn_data[SW +: SW] = SW'($urandom);
        syn_ready = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("sat_quiet", {syn_ack, key_start}, 6'd0);
        end
`ifdef BCH_SCHED_STALL_CNT_EN
        check("sat_stall", stall_cnt, 16'd20);
`endif
        key_busy = 2'b01;
        @(negedge clk);
        check("rel_wait", syn_ack, 4'b0000);
        @(negedge clk);
        check("rel_ack", syn_ack, 4'b0010);
        check("rel_start", key_start, 2'b10);
        check("rel_chan", key_chan[3:2], 2'd1);
        check("rel_syn", key_syn[SW +: SW], syn_data[SW +: SW]);
        syn_ready = '0;

        // stuck solver 0: everything goes to slot 1
        do_reset();
        syn_ready = 4'b0001;
        @(negedge clk);
        check("stuck_first", key_start, 2'b01);
        syn_ready = '0;
        for (int ch = 1; ch < NCH; ch++) begin
            syn_data[ch*SW +: SW] = SW'($urandom);
            syn_ready = '0;
            syn_ready[ch] = 1'b1;
            got = 0;
            for (int w = 0; w < 10 && got == 0; w++) begin
                @(negedge clk);
                if (syn_ack != 0) begin
                    got = 1;
                    check("stuck_slot", key_start, 2'b10);
                    check("stuck_chan", key_chan[3:2], ch);
                    syn_ready   = '0;
                    key_busy[1] = 1'b1;
                end
            end
            check("stuck_ack_seen", got, 1);
            @(negedge clk);
            key_busy[1] = 1'b0;
        end

        // reset while slot 0 is still launched
        syn_ready = 4'b0100;
        got = 0;
        for (int w = 0; w < 10 && got == 0; w++) begin
            @(negedge clk);
            if (syn_ack != 0) got = 1;
        end
        check("mid_ack_seen", got, 1);
        reset_n   = 1'b0;
        syn_ready = '0;
        #1;
        check("mid_rst_out", {syn_ack, key_start, key_syn, key_chan}, 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        syn_ready = 4'b1010;
        @(negedge clk);
        check("mid_start", key_start, 2'b01);
        check("mid_ack", syn_ack, 4'b0010);
        check("mid_chan", key_chan[1:0], 2'd1);
        syn_ready = '0;

        // randomized traffic against the model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            check("rnd_ack", syn_ack, m_ack);
            check("rnd_start", key_start, m_start);
            check("rnd_syn", key_syn, m_syn);
            check("rnd_chan", key_chan, m_chan);
`ifdef BCH_SCHED_STALL_CNT_EN
            check("rnd_stall", stall_cnt, m_stall);
`endif
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_ack[ch]) begin
                    if ($urandom_range(0, 1) == 1)
                        syn_data[ch*SW +: SW] = SW'($urandom);
                    else
                        syn_ready[ch] = 1'b0;
                end else if (!syn_ready[ch] && $urandom_range(0, 3) == 0) begin
                    syn_ready[ch] = 1'b1;
                    syn_data[ch*SW +: SW] = SW'($urandom);
                end
            end
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 3) == 0) key_busy[k] = ~key_busy[k];
            end
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
